multi_tone_pdm: RTL and testbench
=================================

MULTI_TONE_PDM -- requirements
Module: multi_tone_pdm

Interface
REQ-001 SHALL have parameter NCH, default 2: number of tone channels, legal range 1..8.
REQ-002 SHALL have parameter SAMP_DIV, default 130: clocks per sample period, minimum 2.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_en, input, 1 bit: command write strobe, one cycle per command.
REQ-006 SHALL have port cmd_addr, input, 8 bits: register address.
REQ-007 SHALL have port cmd_data, input, 16 bits: write data.
REQ-008 SHALL have port cmd_err, output, 1 bit: one-cycle pulse when a write targets an invalid address.
REQ-009 SHALL have port sample_valid, output, 1 bit: one-cycle pulse when sample_out updates.
REQ-010 SHALL have port sample_out, output, 16*NCH bits: channel c occupies bits [16c+15:16c], unsigned, midscale 0x8000.
REQ-011 SHALL have port pdm_out, output, NCH bits: per-channel 1-bit PDM stream.

Function
REQ-012 SHALL decode addresses as cmd_addr[7:4] = channel and cmd_addr[3:0] = register: 0 tuning (16 b), 1 phase offset (16 b), 2 amplitude (cmd_data[7:0], unsigned), 3 mode (cmd_data[1:0]: 0 off, 1 square, 2 saw, 3 triangle); unused data bits are ignored.
REQ-013 SHALL treat address 0xF0 as the global control register; cmd_data[0]=1 sets sync_pending, and cmd_data[0]=0 has no effect.
REQ-014 SHALL ignore writes where the channel is >= NCH (other than 0xF0) or the register index is > 3, leaving all state unchanged and pulsing cmd_err high in the following cycle.
REQ-015 SHALL apply writes at the edge where cmd_en=1; a write coincident with a tick is not seen by that tick's computation.
REQ-016 SHALL keep a sample counter that resets to 1, increments each clock, and on reaching SAMP_DIV asserts the internal tick for that cycle and reloads to 1.
REQ-017 SHALL, at each tick and per channel, compute p = (acc + offset) mod 2^16 from the pre-update acc, then update acc to (acc + tuning) mod 2^16, or to 0 when sync_pending is set.
REQ-018 SHALL clear sync_pending at the tick that applies it; a sync write coincident with a tick applies at the next tick.
REQ-019 SHALL form the signed 16-bit value s from p as follows: off -> 0; square -> +32767 if p[15]=0, else -32767; saw -> p XOR 0x8000; triangle -> {p[14:0],0} - 32768 if p[15]=0, else 32767 - {p[14:0],0}, computed at 17 bits.
REQ-020 SHALL scale the result as (s * amplitude) arithmetically shifted right by 8 (24-bit product, floor), then XOR 0x8000 to give the unsigned output.
REQ-021 SHALL register sample_out at the tick edge and assert sample_valid for exactly the next cycle, so that the first pulse occurs SAMP_DIV clocks after reset deasserts and the pulses repeat every SAMP_DIV clocks.
REQ-022 SHALL run a first-order PDM per channel every clock: sum = err + sample (17 bits), pdm_out <= sum[16], err <= sum[15:0].

Reset
REQ-023 SHALL, while rst=1, set tuning, offset, amplitude, mode, acc, err and sync_pending to 0, the counter to 1, sample_out to 0x8000 per channel, and pdm_out, sample_valid and cmd_err to 0.
REQ-024 SHALL make reset override cmd_en, so that a write during rst is discarded, and an assertion mid-operation restarts timing from REQ-021.

Verification (bench uses NCH=2, SAMP_DIV=4)
REQ-025 SHALL test post-reset idle: release rst with no writes -> sample_out=0x8000_8000, sample_valid every 4 clocks, pdm_out per channel 0,1,0,1,...
REQ-026 SHALL test square: ch0 tuning=0x4000, amp=0xFF, mode=1 -> consecutive ch0 samples 0xFF7F, 0xFF7F, 0x0080, 0x0080, repeating.
REQ-027 SHALL test saw with offset: ch1 tuning=0x2000, offset=0x8000, amp=0x80, mode=2 -> ch1 samples 0x8000, 0x9000, 0xA000, ...
REQ-028 SHALL test invalid addresses: writes to 0x25 and 0x04 -> cmd_err pulses one cycle after each write, and all outputs are unchanged.
REQ-029 SHALL test sync: ch0 tuning=0x1000 and ch1 tuning=0x3000 run for 3 samples, then write 0xF0 with data 0x0001 -> after the next tick both acc are 0, and the following sample on each channel equals its offset-only value.
REQ-030 SHALL test reset mid-operation: rst high for 1 cycle while square is active -> sample_out=0x8000_8000, registers are cleared, and the next sample_valid occurs 4 clocks after release.

Source files
------------

// File: rtl/multi_tone_pdm.sv
// Multi-channel tone generator (off/square/saw/triangle) with per-channel first-order PDM.
// Samples update one clock after each sample tick; command writes are always accepted (no backpressure).
module multi_tone_pdm #(
  parameter int NCH      = 2,
  parameter int SAMP_DIV = 130
) (
  input  logic                i_clk,
  input  logic                rst,
  input  logic                cmd_en,
  input  logic [7:0]          cmd_addr,
  input  logic [15:0]         cmd_data,
  output logic                cmd_err,
  output logic                sample_valid,
  output logic [16*NCH-1:0]   sample_out,
  output logic [NCH-1:0]      pdm_out
);

  localparam int CW = $clog2(SAMP_DIV + 1);

  logic [CW-1:0]     r_cnt;
  logic [15:0]       r_tuning [NCH];
  logic [15:0]       r_offset [NCH];
  logic [15:0]       r_acc    [NCH];
  logic [15:0]       r_err    [NCH];
  logic [7:0]        r_amp    [NCH];
  logic [1:0]        r_mode   [NCH];
  logic              r_sync;
  logic [16*NCH-1:0] r_sample;
  logic [NCH-1:0]    r_pdm;
  logic              r_vld;
  logic              r_cerr;

  logic              w_tick;
  logic [3:0]        w_ch;
  logic [3:0]        w_reg;
  logic              w_glob;
  logic              w_ch_ok;
  logic              w_reg_ok;
  logic              w_wr;
  logic              w_bad;
  logic [15:0]       w_new [NCH];
  logic [16:0]       w_sum [NCH];
  logic [8*NCH-1:0]  w_frac;
  logic              w_unused;

  assign w_tick   = (r_cnt == CW'(SAMP_DIV));
  assign w_ch     = cmd_addr[7:4];
  assign w_reg    = cmd_addr[3:0];
  assign w_glob   = (cmd_addr == 8'hF0);
  assign w_ch_ok  = ({28'd0, w_ch} < 32'(NCH));
  assign w_reg_ok = (w_reg <= 4'd3);
  assign w_wr     = cmd_en && !w_glob && w_ch_ok && w_reg_ok;
  assign w_bad    = cmd_en && !w_glob && !(w_ch_ok && w_reg_ok);

  // Fractional product bits are discarded by the floor shift.
  assign w_unused = ^w_frac;

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    logic [15:0]        w_p;
    logic signed [15:0] w_s;
    logic signed [23:0] w_prod;

    assign w_p = r_acc[g] + r_offset[g];

    always_comb begin
      w_s = '0;
      case (r_mode[g])
        2'd1:    w_s = w_p[15] ? 16'sh8001 : 16'sh7FFF;
        2'd2:    w_s = w_p ^ 16'h8000;
        // Exact result always fits 16 signed bits, so modular 16-bit math is exact.
        2'd3:    w_s = w_p[15] ? (16'h7FFF - {w_p[14:0], 1'b0}) : ({w_p[14:0], 1'b0} ^ 16'h8000);
        default: w_s = '0;
      endcase
    end

    assign w_prod = $signed({{8{w_s[15]}}, w_s}) * $signed({16'd0, r_amp[g]});
    assign w_new[g] = w_prod[23:8] ^ 16'h8000;
    assign w_frac[8*g +: 8] = w_prod[7:0];
    assign w_sum[g] = {1'b0, r_err[g]} + {1'b0, r_sample[16*g +: 16]};
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_cnt    <= CW'(1);
      r_sync   <= 1'b0;
      r_vld    <= 1'b0;
      r_cerr   <= 1'b0;
      r_pdm    <= '0;
      r_sample <= {NCH{16'h8000}};
      for (int c = 0; c < NCH; c++) begin
        r_tuning[c] <= '0;
        r_offset[c] <= '0;
        r_acc[c]    <= '0;
        r_err[c]    <= '0;
        r_amp[c]    <= '0;
        r_mode[c]   <= '0;
      end
    end else begin
      r_cnt  <= w_tick ? CW'(1) : r_cnt + CW'(1);
      r_vld  <= w_tick;
      r_cerr <= w_bad;

      for (int c = 0; c < NCH; c++) begin
        r_err[c] <= w_sum[c][15:0];
        r_pdm[c] <= w_sum[c][16];
        if (w_tick) begin
          r_sample[16*c +: 16] <= w_new[c];
          r_acc[c]             <= r_sync ? 16'd0 : r_acc[c] + r_tuning[c];
        end
        if (w_wr && (w_ch == 4'(c))) begin
          case (w_reg)
            4'd0:    r_tuning[c] <= cmd_data;
            4'd1:    r_offset[c] <= cmd_data;
            4'd2:    r_amp[c]    <= cmd_data[7:0];
            4'd3:    r_mode[c]   <= cmd_data[1:0];
            default: ;
          endcase
        end
      end

      // A sync write landing on a tick survives that tick's clear.
      if (w_tick)
        r_sync <= 1'b0;
      if (cmd_en && w_glob && cmd_data[0])
        r_sync <= 1'b1;
    end
  end

  assign cmd_err      = r_cerr;
  assign sample_valid = r_vld;
  assign sample_out   = r_sample;
  assign pdm_out      = r_pdm;

endmodule

// File: tb/tb_multi_tone_pdm.sv
// Bench for multi_tone_pdm: directed scenarios plus random command traffic, all checked
// every clock against an arithmetic reference model.
module tb_multi_tone_pdm;
  localparam int NCH = 2;
  localparam int SD  = 4;

  logic        i_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_en = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_err;
  logic        sample_valid;
  logic [31:0] sample_out;
  logic [1:0]  pdm_out;

  always #5 i_clk = ~i_clk;

  multi_tone_pdm #(.NCH(NCH), .SAMP_DIV(SD)) dut (
    .i_clk(i_clk), .rst(rst), .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_err(cmd_err), .sample_valid(sample_valid), .sample_out(sample_out), .pdm_out(pdm_out)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  int m_tun[NCH], m_off[NCH], m_amp[NCH], m_mode[NCH], m_acc[NCH];
  int m_samp[NCH], m_err[NCH], m_pdm[NCH];
  int m_sync, m_clk, m_vld, m_cerr;

  logic [15:0] s0, s1;
  logic [15:0] sq_exp [4];
  int o0, o1, a1, k;
  bit got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Tone value for phase p, scaled and offset to the unsigned output code.
  function automatic int wave(int mode, int p, int amp);
    int s, v;
    case (mode)
      0:       s = 0;
      1:       s = (p < 32768) ? 32767 : -32767;
      2:       s = p - 32768;
      default: s = (p < 32768) ? (2 * p - 32768) : (32767 - 2 * (p - 32768));
    endcase
    v = (s * amp) >>> 8;
    v = v & 32'hFFFF;
    return v ^ 32'h8000;
  endfunction

  function automatic bit bad_addr(logic [7:0] a);
    return (a != 8'hF0) && ((a[7:4] >= NCH) || (a[3:0] > 4'd3));
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int sum, p, ch;
    bit tick;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_tun[c] = 0; m_off[c] = 0; m_amp[c] = 0; m_mode[c] = 0; m_acc[c] = 0;
        m_samp[c] = 32768; m_err[c] = 0; m_pdm[c] = 0;
      end
      m_sync = 0; m_clk = 0; m_vld = 0; m_cerr = 0;
    end else begin
      m_clk++;
      tick = ((m_clk % SD) == 0);
      m_vld = tick;
      m_cerr = cmd_en && bad_addr(cmd_addr);
      for (int c = 0; c < NCH; c++) begin
        sum = m_err[c] + m_samp[c];
        m_pdm[c] = sum / 65536;
        m_err[c] = sum % 65536;
      end
      if (tick) begin
        for (int c = 0; c < NCH; c++) begin
          p = (m_acc[c] + m_off[c]) % 65536;
          m_samp[c] = wave(m_mode[c], p, m_amp[c]);
          m_acc[c] = m_sync ? 0 : (m_acc[c] + m_tun[c]) % 65536;
        end
        m_sync = 0;
      end
      if (cmd_en && !bad_addr(cmd_addr)) begin
        if (cmd_addr == 8'hF0) begin
          if (cmd_data[0]) m_sync = 1;
        end else begin
          ch = int'(cmd_addr[7:4]);
          case (cmd_addr[3:0])
            4'd0:    m_tun[ch]  = int'(cmd_data);
            4'd1:    m_off[ch]  = int'(cmd_data);
            4'd2:    m_amp[ch]  = int'(cmd_data[7:0]);
            default: m_mode[ch] = int'(cmd_data[1:0]);
          endcase
        end
      end
    end
  endtask

  task automatic step();
    logic [31:0] exp_out;
    model_edge();
    @(posedge i_clk);
    #1;
    exp_out = {m_samp[1][15:0], m_samp[0][15:0]};
    chk("sample_out", sample_out, exp_out);
    chk("sample_valid", 32'(sample_valid), 32'(m_vld));
    chk("pdm_out", 32'(pdm_out), {30'd0, m_pdm[1][0], m_pdm[0][0]});
    chk("cmd_err", 32'(cmd_err), 32'(m_cerr));
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cmd_en = 1'b1; cmd_addr = a; cmd_data = d;
    step();
    cmd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_vld(output logic [15:0] v0, output logic [15:0] v1);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * SD && !seen; i++) begin
      step();
      seen = sample_valid;
    end
    if (!seen) chk("vld_wait", 32'(sample_valid), 32'd1);
    v0 = sample_out[15:0];
    v1 = sample_out[31:16];
  endtask

  initial begin
    // idle after reset
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < SD; i++) step();
    chk("first_vld", 32'(sample_valid), 32'd1);
    chk("idle_out", sample_out, 32'h8000_8000);
    for (int i = 0; i < 12; i++) step();

    // square on ch0
    sq_exp[0] = 16'hFF7F; sq_exp[1] = 16'hFF7F; sq_exp[2] = 16'h0080; sq_exp[3] = 16'h0080;
    do_reset();
    wr(8'h00, 16'h4000);
    wr(8'h02, 16'h00FF);
    wr(8'h03, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      wait_vld(s0, s1);
      chk("square_ch0", 32'(s0), 32'(sq_exp[i % 4]));
    end

    // saw with offset on ch1; the mode write lands on the first tick
    do_reset();
    wr(8'h10, 16'h2000);
    wr(8'h11, 16'h8000);
    wr(8'h12, 16'h0080);
    wr(8'h13, 16'h0002);
    chk("saw_tick0", 32'(sample_valid), 32'd1);
    chk("saw_s0", 32'(sample_out[31:16]), 32'h8000);
    for (int i = 1; i < 4; i++) begin
      wait_vld(s0, s1);
      chk("saw_ch1", 32'(s1), 32'h8000 + 32'h1000 * 32'(i));
    end

    // invalid addresses
    wr(8'h25, 16'($urandom));
    chk("err_25", 32'(cmd_err), 32'd1);
    step();
    chk("err_25_end", 32'(cmd_err), 32'd0);
    wr(8'h04, 16'($urandom));
    chk("err_04", 32'(cmd_err), 32'd1);
    step();
    chk("err_04_end", 32'(cmd_err), 32'd0);

    // sync
    o0 = int'($urandom_range(0, 65535));
    o1 = int'($urandom_range(0, 65535));
    a1 = int'($urandom_range(1, 255));
    do_reset();
    wr(8'h00, 16'h1000); wr(8'h01, 16'(o0)); wr(8'h02, 16'h00FF); wr(8'h03, 16'h0002);
    wr(8'h10, 16'h3000); wr(8'h11, 16'(o1)); wr(8'h12, 16'(a1));   wr(8'h13, 16'h0003);
    for (int i = 0; i < 3; i++) wait_vld(s0, s1);
    wr(8'hF0, 16'h0001);
    wait_vld(s0, s1);
    wait_vld(s0, s1);
    chk("sync_ch0", 32'(s0), 32'(wave(2, o0, 255)));
    chk("sync_ch1", 32'(s1), 32'(wave(3, o1, a1)));
    wait_vld(s0, s1);
    chk("post_sync_ch0", 32'(s0), 32'(wave(2, (o0 + 32'h1000) % 65536, 255)));

    // reset mid-operation
    do_reset();
    wr(8'h00, 16'h4000);
    wr(8'h02, 16'h00FF);
    wr(8'h03, 16'h0001);
    wait_vld(s0, s1);
    wait_vld(s0, s1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out", sample_out, 32'h8000_8000);
    chk("rst_vld", 32'(sample_valid), 32'd0);
    k = 0;
    got = 1'b0;
    while (!got && k < 3 * SD) begin
      step();
      k++;
      got = sample_valid;
    end
    chk("rst_vld_lat", 32'(k), 32'(SD));
    chk("rst_cleared", sample_out, 32'h8000_8000);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (r < 40) begin
        case ($urandom_range(0, 5))
          0:       cmd_addr = 8'hF0;
          1:       cmd_addr = 8'($urandom);
          default: cmd_addr = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 4))};
        endcase
        cmd_en = 1'b1;
        cmd_data = 16'($urandom);
        step();
        cmd_en = 1'b0;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
